// File: rtl/collision_arbiter.sv
// Per-frame collision arbiter. It collects player-vs-object pixel overlaps
// over a frame. At the next start of frame it reports one prioritised hit,
// then holds off further reports for a programmable number of frames.
module collision_arbiter #(
    parameter int NUM_OBJ         = 6,
    parameter int COOLDOWN_FRAMES = 4,
    parameter int LOW_IDX_FIRST   = 1,
    parameter int CNT_W           = 8,
    parameter int IDX_W           = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               playerReq,
    input  logic [NUM_OBJ-1:0] objReq,
    input  logic [NUM_OBJ-1:0] objMask,
    input  logic               clearCount,
    output logic               overlapNow,
    output logic               hitPulse,
    output logic [IDX_W-1:0]   hitIndex,
    output logic [NUM_OBJ-1:0] hitVec,
    output logic               cooldownActive,
    output logic [CNT_W-1:0]   hitCount
);

    localparam logic [0:0] ST_ARMED    = 1'b0;
    localparam logic [0:0] ST_COOLDOWN = 1'b1;

    // Counter is wide enough to hold the full cooldown length.
    localparam int CD_W = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [CD_W-1:0]  CD_LOAD = CD_W'(COOLDOWN_FRAMES);
    localparam logic [CD_W-1:0]  CD_ONE  = CD_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_OBJ-1:0] cur_ov;
    logic [IDX_W-1:0]   win_idx;

    logic [NUM_OBJ-1:0] acc_q, acc_d;
    logic [0:0]         state_q, state_d;
    logic [CD_W-1:0]    cd_q, cd_d;
    logic               overlap_q, overlap_d;
    logic               hit_pulse_q, hit_pulse_d;
    logic [IDX_W-1:0]   hit_index_q, hit_index_d;
    logic [NUM_OBJ-1:0] hit_vec_q, hit_vec_d;
    logic               cooldown_q, cooldown_d;
    logic [CNT_W-1:0]   hit_count_q, hit_count_d;

    // A channel overlaps when the player and an enabled object share this pixel.
    generate
        for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_ov
            assign cur_ov[gi] = objReq[gi] & objMask[gi] & playerReq;
        end
    endgenerate

    // Choose the reported channel from the finished frame's accumulator.
    // The loop direction sets which end of the vector has priority.
    always_comb begin
        win_idx = '0;
        if (LOW_IDX_FIRST != 0) begin
            for (int i = NUM_OBJ - 1; i >= 0; i--) begin
                if (acc_q[i]) win_idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < NUM_OBJ; i++) begin
                if (acc_q[i]) win_idx = IDX_W'(i);
            end
        end
    end

    // Next-state logic. Accumulation, hit reporting, cooldown and the counter.
    always_comb begin
        state_d     = state_q;
        cd_d        = cd_q;
        hit_index_d = hit_index_q;
        hit_vec_d   = hit_vec_q;
        hit_count_d = hit_count_q;
        hit_pulse_d = 1'b0;
        overlap_d   = |cur_ov;
        // An overlap seen in the SOF cycle already belongs to the new frame.
        acc_d       = startOfFrame ? cur_ov : (acc_q | cur_ov);

        if (startOfFrame) begin
            hit_vec_d = acc_q;
            if (state_q == ST_ARMED) begin
                if (|acc_q) begin
                    hit_pulse_d = 1'b1;
                    hit_index_d = win_idx;
                    if (hit_count_q != {CNT_W{1'b1}}) hit_count_d = hit_count_q + CNT_ONE;
                    if (COOLDOWN_FRAMES > 0) begin
                        state_d = ST_COOLDOWN;
                        cd_d    = CD_LOAD;
                    end
                end
            end else begin
                cd_d = cd_q - CD_ONE;
                if (cd_q == CD_ONE) state_d = ST_ARMED;
            end
        end

        // A clear overrides an increment in the same cycle.
        if (clearCount) hit_count_d = '0;

        cooldown_d = (state_d == ST_COOLDOWN);
    end

    // Register the state. A reset drops any pending cooldown and partial frame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc_q       <= '0;
            state_q     <= ST_ARMED;
            cd_q        <= '0;
            overlap_q   <= 1'b0;
            hit_pulse_q <= 1'b0;
            hit_index_q <= '0;
            hit_vec_q   <= '0;
            cooldown_q  <= 1'b0;
            hit_count_q <= '0;
        end else begin
            acc_q       <= acc_d;
            state_q     <= state_d;
            cd_q        <= cd_d;
            overlap_q   <= overlap_d;
            hit_pulse_q <= hit_pulse_d;
            hit_index_q <= hit_index_d;
            hit_vec_q   <= hit_vec_d;
            cooldown_q  <= cooldown_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign overlapNow     = overlap_q;
    assign hitPulse       = hit_pulse_q;
    assign hitIndex       = hit_index_q;
    assign hitVec         = hit_vec_q;
    assign cooldownActive = cooldown_q;
    assign hitCount       = hit_count_q;

endmodule

// File: tb/tb_collision_arbiter.sv
// Bench for collision_arbiter. Instance 0 uses the default parameters.
// Instance 1 uses high-index priority, no cooldown and a 2-bit counter.
// Both instances receive the same stimulus and are checked against a
// frame-level reference model.
module tb_collision_arbiter;

    localparam int N = 6;

    logic         clk = 1'b0;
    logic         resetN = 1'b0;
    logic         startOfFrame = 1'b0;
    logic         playerReq = 1'b0;
    logic [N-1:0] objReq = '0;
    logic [N-1:0] objMask = '1;
    logic         clearCount = 1'b0;

    logic         ov0, pulse0, cd0, ov1, pulse1, cd1;
    logic [2:0]   idx0, idx1;
    logic [N-1:0] vec0, vec1;
    logic [7:0]   cnt0;
    logic [1:0]   cnt1;

    always #5 clk = ~clk;

    collision_arbiter dut0 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .playerReq(playerReq),
        .objReq(objReq), .objMask(objMask), .clearCount(clearCount),
        .overlapNow(ov0), .hitPulse(pulse0), .hitIndex(idx0), .hitVec(vec0),
        .cooldownActive(cd0), .hitCount(cnt0)
    );

    collision_arbiter #(.NUM_OBJ(6), .COOLDOWN_FRAMES(0), .LOW_IDX_FIRST(0), .CNT_W(2)) dut1 (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .playerReq(playerReq),
        .objReq(objReq), .objMask(objMask), .clearCount(clearCount),
        .overlapNow(ov1), .hitPulse(pulse1), .hitIndex(idx1), .hitVec(vec1),
        .cooldownActive(cd1), .hitCount(cnt1)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model. The accumulated frame and the live overlap do not
    // depend on the parameters, so both instances share them.
    int m_acc, m_vec, m_ov;
    int m_cool[2], m_cnt[2], m_idx[2], m_pulse[2];
    int p_cd[2]   = '{4, 0};
    int p_low[2]  = '{1, 0};
    int p_max[2]  = '{255, 3};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int winner(input int v, input int low);
        if (low != 0) begin
            for (int i = 0; i < N; i++) if (v[i]) return i;
        end else begin
            for (int i = N - 1; i >= 0; i--) if (v[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_vec = 0; m_ov = 0;
        for (int k = 0; k < 2; k++) begin
            m_cool[k] = 0; m_cnt[k] = 0; m_idx[k] = 0; m_pulse[k] = 0;
        end
    endtask

    // Apply one clock edge to the model, using the inputs present at that edge.
    task automatic model_edge();
        int cur;
        cur = playerReq ? int'(objReq & objMask) : 0;
        m_ov = (cur != 0) ? 1 : 0;
        for (int k = 0; k < 2; k++) begin
            m_pulse[k] = 0;
            if (startOfFrame) begin
                if (m_cool[k] > 0) begin
                    m_cool[k]--;
                end else if (m_acc != 0) begin
                    m_pulse[k] = 1;
                    m_idx[k]   = winner(m_acc, p_low[k]);
                    m_cnt[k]   = (m_cnt[k] + 1 > p_max[k]) ? p_max[k] : m_cnt[k] + 1;
                    m_cool[k]  = p_cd[k];
                end
            end
            if (clearCount) m_cnt[k] = 0;
        end
        if (startOfFrame) begin
            m_vec = m_acc;
            m_acc = cur;
        end else begin
            m_acc = m_acc | cur;
        end
    endtask

    task automatic check_all();
        chk("ov0", ov0, m_ov);        chk("ov1", ov1, m_ov);
        chk("pulse0", pulse0, m_pulse[0]); chk("pulse1", pulse1, m_pulse[1]);
        chk("idx0", idx0, m_idx[0]);  chk("idx1", idx1, m_idx[1]);
        chk("vec0", vec0, m_vec);     chk("vec1", vec1, m_vec);
        chk("cd0", cd0, (m_cool[0] > 0) ? 1 : 0);
        chk("cd1", cd1, (m_cool[1] > 0) ? 1 : 0);
        chk("cnt0", cnt0, m_cnt[0]);  chk("cnt1", cnt1, m_cnt[1]);
    endtask

    // Drive one cycle of inputs, clock it, then compare everything 1 time unit later.
    task automatic step(input logic sof, input logic pr, input logic [N-1:0] oreq,
                        input logic [N-1:0] omask, input logic clr);
        startOfFrame = sof; playerReq = pr; objReq = oreq; objMask = omask; clearCount = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Assert the asynchronous reset between edges. Outputs must clear before any clock edge.
    task automatic do_reset();
        startOfFrame = 0; playerReq = 0; objReq = '0; objMask = '1; clearCount = 0;
        resetN = 1'b0;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    initial begin
        model_reset();
        #3;
        do_reset();

        // Ten cycles of overlap on channel 2, then a frame boundary.
        for (int i = 0; i < 10; i++) step(0, 1, 6'b000100, 6'b111111, 0);
        step(1, 0, '0, 6'b111111, 0);
        chk("t1_pulse", pulse0, 1);
        chk("t1_idx", idx0, 2);
        chk("t1_vec", vec0, 6'b000100);
        chk("t1_cnt", cnt0, 1);
        chk("t1_cd", cd0, 1);
        step(0, 0, '0, 6'b111111, 0);
        chk("t1_width", pulse0, 0);

        // Overlap on channels 1 and 4 in the same frame.
        step(0, 1, 6'b010010, 6'b111111, 0);
        step(1, 0, '0, 6'b111111, 0);
        chk("t2_idx1", idx1, 4);
        chk("t2_vec", vec0, 6'b010010);

        // A masked channel gives no live overlap.
        step(0, 1, 6'b000100, 6'b111011, 0);
        chk("t3_ovl", ov0, 0);

        // Reset during cooldown while the accumulator holds a hit.
        step(0, 1, 6'b001000, 6'b111111, 0);
        do_reset();
        step(0, 1, 6'b100000, 6'b111111, 0);
        step(1, 0, '0, 6'b111111, 0);
        chk("t4_pulse", pulse0, 1);
        chk("t4_idx", idx0, 5);

        // Overlap only in the SOF cycle belongs to the new frame.
        for (int i = 0; i < 50; i++) step((i % 10) == 0, 0, '0, 6'b111111, 0);
        step(1, 1, 6'b000010, 6'b111111, 0);
        chk("t5_nopulse", pulse1, 0);
        step(1, 0, '0, 6'b111111, 0);
        chk("t5_pulse", pulse1, 1);
        chk("t5_idx", idx1, 1);

        // Randomised traffic, including saturation, clears and a mid-run reset.
        for (int c = 0; c < 4000; c++) begin
            logic [N-1:0] r_req, r_mask;
            if (c == 2000) do_reset();
            r_req  = N'($urandom_range(0, 63) & $urandom_range(0, 63));
            r_mask = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 63)) : 6'b111111;
            step($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), r_req, r_mask,
                 $urandom_range(0, 60) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/collision_arbiter.md
Name: collision_arbiter

Overview:
Parametrised per-frame collision arbiter for the VGA game. It sits between the object drawers' pixel-request outputs and the game FSM. Each frame it accumulates player-vs-object pixel overlaps across NUM_OBJ channels. At start of frame it reports one prioritised hit event, followed by a programmable multi-frame cooldown ("invulnerability" window). It also keeps a saturating hit counter.

Parameters:
NUM_OBJ, 6, number of object request channels (1..16)
COOLDOWN_FRAMES, 4, frames after a reported hit during which new hits are not reported (0 = no cooldown)
LOW_IDX_FIRST, 1, 1: lowest set index wins arbitration; 0: highest set index wins
CNT_W, 8, width of hitCount
IDX_W, $clog2(NUM_OBJ) (min 1), width of hitIndex

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse per frame
playerReq  in  1  player pixel being drawn this cycle
objReq  in  NUM_OBJ  per-object pixel request
objMask  in  NUM_OBJ  1 = channel enabled for collision
clearCount  in  1  synchronous clear of hitCount
overlapNow  out  1  registered playerReq & |(objReq & objMask), 1-cycle latency
hitPulse  out  1  one-cycle hit event, at most one per frame
hitIndex  out  IDX_W  winning channel, valid with hitPulse and held until the next hitPulse
hitVec  out  NUM_OBJ  all channels overlapped in the previous frame
cooldownActive  out  1  high while in COOLDOWN
hitCount  out  CNT_W  number of reported hits, saturating

Behaviour:
- Reset: asynchronous, active-low, on resetN. Reset values:
  - all outputs 0
  - accumulator acc 0
  - state ARMED
  - cooldown counter 0
- acc register (NUM_OBJ bits):
  - Each non-SOF cycle: acc <= acc | (objReq & objMask & {NUM_OBJ{playerReq}}).
  - On a startOfFrame cycle: acc <= the current-cycle overlap only. Overlap sampled in the SOF cycle belongs to the new frame.
- On the startOfFrame cycle, the following are registered and visible the next cycle:
  - hitVec <= acc (old value), updated every frame regardless of state.
  - ARMED and acc != 0:
    - hitPulse <= 1
    - hitIndex <= winner per LOW_IDX_FIRST
    - hitCount <= hitCount+1, saturating at all-ones
    - if COOLDOWN_FRAMES > 0: state <= COOLDOWN, cd <= COOLDOWN_FRAMES; otherwise stay ARMED.
  - COOLDOWN: cd <= cd-1. When cd becomes 0, state <= ARMED, effective from the next SOF. Hits in cooldown frames appear in hitVec but produce no pulse or count.
- hitPulse defaults to 0 on all other cycles. Its width is exactly 1 cycle.
- cooldownActive = (state == COOLDOWN), registered. It is high for exactly COOLDOWN_FRAMES frames after the pulse frame.
- clearCount:
  - Sets hitCount to 0.
  - If a hit increment falls in the same cycle, clear wins and the count is 0.
- objMask changes take effect on the next cycle's accumulation. Already-accumulated bits are not removed.
- startOfFrame high on consecutive cycles is treated as separate frames; no error handling.
- overlapNow updates every cycle, independent of state and frame.
- Reset mid-frame discards acc and any pending cooldown.

Test Plan:
- Reset, then NUM_OBJ=6, playerReq=1 with objReq=6'b000100 for 10 cycles mid-frame, then SOF -> next cycle hitPulse=1 for 1 cycle, hitIndex=2, hitVec=000100, hitCount=1, cooldownActive=1.
- Same frame with overlaps on channels 1 and 4 -> LOW_IDX_FIRST=1 gives hitIndex=1; LOW_IDX_FIRST=0 gives hitIndex=4; hitVec=010010 in both cases.
- COOLDOWN_FRAMES=4, overlap every frame -> pulses on frames 1 and 6 only, cooldownActive high for exactly 4 frames between them, hitCount=2 after frame 6.
- Overlap only in the SOF cycle of frame N -> no pulse at SOF N. Pulse at SOF N+1 with that index.
- objMask=111011 with overlap on channel 2 only -> overlapNow=0, no pulse, hitVec=0. With CNT_W=2, four reported hits -> hitCount saturates at 3. clearCount asserted on a hit cycle -> hitCount=0.
- Assert resetN=0 during cooldown with acc nonzero -> all outputs 0 and state ARMED. The first overlap frame after reset produces a pulse.
